// File: rtl/mem_stage.sv
// Memory-access stage: feeds mem_wb and runs a request/acknowledge data-bus transaction for
// loads and stores, with big-endian lane selection, load extension and timeout abort.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  wd_i,
  input  logic        whilo_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_wd,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        stallreq,
  output logic        align_err,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack
);

  localparam logic [3:0] OpLb  = 4'b0001;
  localparam logic [3:0] OpLbu = 4'b0010;
  localparam logic [3:0] OpLh  = 4'b0011;
  localparam logic [3:0] OpLhu = 4'b0100;
  localparam logic [3:0] OpLw  = 4'b0101;
  localparam logic [3:0] OpSb  = 4'b1001;
  localparam logic [3:0] OpSh  = 4'b1010;
  localparam logic [3:0] OpSw  = 4'b1011;

  // The IDLE request cycle counts as one, and the counter reads 0 in the first WAIT cycle,
  // so the abort lands in request cycle TIMEOUT.
  localparam logic [7:0] AbortCnt = 8'(TIMEOUT - 2);

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;
  typedef enum logic {StIdle, StWait} state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return op inside {OpLb, OpLbu, OpLh, OpLhu, OpLw};
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return op inside {OpSb, OpSh, OpSw};
  endfunction

  function automatic size_e op_size(input logic [3:0] op);
    case (op)
      OpLb, OpLbu, OpSb: return SzByte;
      OpLh, OpLhu, OpSh: return SzHalf;
      default:           return SzWord;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input size_e size, input logic [1:0] lo);
    case (size)
      SzByte:  return 4'b1000 >> lo;
      SzHalf:  return lo[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input size_e size, input logic [31:0] d);
    case (size)
      SzByte:  return {4{d[7:0]}};
      SzHalf:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SzByte:  return 1'b0;
      SzHalf:  return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_data(input logic [3:0] op, input logic [1:0] lo,
                                            input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = rdata[31:24];
      2'd1:    b = rdata[23:16];
      2'd2:    b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    h = lo[1] ? rdata[15:0] : rdata[31:16];
    case (op)
      OpLb:    return {{24{b[7]}}, b};
      OpLbu:   return {24'b0, b};
      OpLh:    return {{16{h[15]}}, h};
      OpLhu:   return {16'b0, h};
      default: return rdata;
    endcase
  endfunction

  // Decode of the live EX/MEM inputs
  logic       live_load;
  logic       live_mem;
  logic       live_misaligned;
  size_e      live_size;
  logic [1:0] live_lo;

  assign live_lo         = mem_addr_i[1:0];
  assign live_load       = op_is_load(mem_op_i);
  assign live_mem        = live_load | op_is_store(mem_op_i);
  assign live_size       = op_size(mem_op_i);
  assign live_misaligned = is_misaligned(live_size, live_lo);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        latch_en;
  logic [29:0] addr_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  op_q;
  logic [1:0]  lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      addr_q  <= 30'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      op_q    <= 4'd0;
      lo_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        addr_q  <= mem_addr_i[31:2];
        sel_q   <= lane_sel(live_size, live_lo);
        we_q    <= ~live_load;
        wdata_q <= store_data(live_size, reg2_i);
        op_q    <= mem_op_i;
        lo_q    <= live_lo;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_en   = 1'b0;
    mem_wreg   = wreg_i;
    mem_wdata  = wdata_i;
    mem_wd     = wd_i;
    mem_whilo  = whilo_i;
    mem_hi     = hi_i;
    mem_lo     = lo_i;
    stallreq   = 1'b0;
    align_err  = 1'b0;
    bus_err    = 1'b0;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = 32'd0;
    dbus_sel   = 4'd0;
    dbus_wdata = 32'd0;

    unique case (state_q)
      StIdle: begin
        if (live_mem && live_misaligned) begin
          align_err = 1'b1;
          mem_wreg  = 1'b0;
          mem_whilo = 1'b0;
        end else if (live_mem) begin
          dbus_req   = 1'b1;
          dbus_we    = ~live_load;
          dbus_addr  = {mem_addr_i[31:2], 2'b00};
          dbus_sel   = lane_sel(live_size, live_lo);
          dbus_wdata = store_data(live_size, reg2_i);
          if (dbus_ack) begin
            if (live_load) mem_wdata = load_data(mem_op_i, live_lo, dbus_rdata);
          end else begin
            stallreq  = 1'b1;
            mem_wreg  = 1'b0;
            mem_whilo = 1'b0;
            state_d   = StWait;
            cnt_d     = 8'd0;
            latch_en  = 1'b1;
          end
        end
      end
      StWait: begin
        dbus_req   = 1'b1;
        dbus_we    = we_q;
        dbus_addr  = {addr_q, 2'b00};
        dbus_sel   = sel_q;
        dbus_wdata = wdata_q;
        if (dbus_ack) begin
          if (!we_q) mem_wdata = load_data(op_q, lo_q, dbus_rdata);
          state_d = StIdle;
        end else if (cnt_q == AbortCnt) begin
          bus_err   = 1'b1;
          mem_wreg  = 1'b0;
          mem_whilo = 1'b0;
          state_d   = StIdle;
        end else begin
          stallreq  = 1'b1;
          mem_wreg  = 1'b0;
          mem_whilo = 1'b0;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reset silences every output immediately, even mid-transaction
    if (rst) begin
      mem_wreg   = 1'b0;
      mem_wdata  = 32'd0;
      mem_wd     = 5'd0;
      mem_whilo  = 1'b0;
      mem_hi     = 32'd0;
      mem_lo     = 32'd0;
      stallreq   = 1'b0;
      align_err  = 1'b0;
      bus_err    = 1'b0;
      dbus_req   = 1'b0;
      dbus_we    = 1'b0;
      dbus_addr  = 32'd0;
      dbus_sel   = 4'd0;
      dbus_wdata = 32'd0;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It sits between the EX/MEM pipeline register and `mem_wb`, and drives every `mem_*` input of `mem_wb`. For load/store instructions it runs a request/acknowledge transaction on the data bus and holds the pipeline with `stallreq` until the transaction completes. It also does byte-lane selection, load sign/zero extension, misalignment detection and bus-timeout abort.

## Interface
Parameters:
- `TIMEOUT`, default 255: request cycles without `dbus_ack` before abort; legal range 2..255.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous reset, active-high
- `wreg_i`  in  1  GPR write enable from EX/MEM
- `wdata_i`  in  32  ALU result from EX/MEM
- `wd_i`  in  5  destination register
- `whilo_i`  in  1  HI/LO write enable
- `hi_i`, `lo_i`  in  32 each  HI/LO values
- `mem_op_i`  in  4  memory op encoding:
  - 0000 none, 0001 LB, 0010 LBU, 0011 LH, 0100 LHU, 0101 LW
  - 1001 SB, 1010 SH, 1011 SW
  - any other value is treated as none
- `mem_addr_i`  in  32  effective address
- `reg2_i`  in  32  store data (rt)
- `mem_wreg`, `mem_wdata`, `mem_wd`, `mem_whilo`, `mem_hi`, `mem_lo`  out  1/32/5/1/32/32  to `mem_wb`
- `stallreq`  out  1  pipeline hold request
- `align_err`  out  1  misaligned access, valid for one cycle
- `bus_err`  out  1  timeout abort, valid for one cycle
- `dbus_req`  out  1  bus request
- `dbus_we`  out  1  1 = write
- `dbus_addr`  out  32  word address; `addr[1:0]` forced to 00
- `dbus_sel`  out  4  byte enables, big-endian
- `dbus_wdata`  out  32  write data
- `dbus_rdata`  in  32  read data, valid with ack
- `dbus_ack`  in  1  completion

## Operation
- **Big-endian lanes**, selected by `addr[1:0]`:
  - Byte access: 00→`sel`=1000 / data[31:24], 01→0100 / [23:16], 10→0010 / [15:8], 11→0001 / [7:0].
  - Halfword access: 00→1100 / [31:16], 10→0011 / [15:0].
  - Word access: 1111.
- **Store data**: the byte or halfword is replicated across all lanes (SB: `{4{reg2_i[7:0]}}`, SH: `{2{reg2_i[15:0]}}`).
- **Load data**: LB/LH sign-extend the selected lane; LBU/LHU zero-extend it.
- **Misalignment**: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠00.
  - No bus request, `align_err`=1, `mem_wreg`=0, `mem_whilo`=0, `stallreq`=0.
- **Non-memory op**: all `mem_*` outputs equal their inputs combinationally; `stallreq`=0; `dbus_req`=0.
- **FSM states**: IDLE, WAIT.
  - **IDLE**, aligned memory op present:
    - `dbus_req`=1, driven from the live inputs.
    - If `dbus_ack`=1 in the same cycle, the access completes there (zero-wait).
    - Otherwise `stallreq`=1 and the FSM moves to WAIT, latching addr/sel/we/wdata/op lane into internal registers.
  - **WAIT**:
    - `dbus_req`=1, driven from the latched registers.
    - On `dbus_ack`: complete and return to IDLE.
    - Timeout: when the request has been asserted for `TIMEOUT` cycles without ack (IDLE cycle counts as 1), abort:
      - `bus_err`=1, `dbus_req` stays asserted that cycle, `stallreq`=0, `mem_wreg`=0, `mem_whilo`=0, return to IDLE.
  - An ack arriving in the abort cycle takes priority: the access completes normally.
- **Completion cycle**:
  - `stallreq`=0, `mem_wreg`=`wreg_i`, `mem_whilo`=`whilo_i`.
  - `mem_wdata` = extended load data for loads; `wdata_i` for stores.
- **Stall cycles**: `mem_wreg`=0 and `mem_whilo`=0 (bubble into `mem_wb`). `mem_wd`, `mem_hi`, `mem_lo` pass through.
- **Wait counter**: 8 bits. Clears on entry to WAIT, increments each WAIT cycle, and never wraps because abort occurs first.

## Timing
- **Reset**: while `rst`=1, state=IDLE, counter=0, and every output is 0 regardless of inputs. This holds mid-transaction: the request drops immediately and is not reissued until `rst` deasserts.
- **Zero-wait access**: no stall; the result reaches `mem_wb` on the next edge.
- **N-cycle ack** (ack in the N-th request cycle): `stallreq` is high for N−1 cycles, and the FSM is back in IDLE after the completion edge.
- The upstream pipeline holds EX/MEM stable while `stallreq`=1. The block does not depend on this in WAIT, because it uses the latched values there.
- **Back-to-back memory ops**: the next request may assert in the cycle immediately after completion. There are no idle bus cycles.
- `dbus_req` never deasserts before ack or abort.

## Test plan
- **LW**, addr 0x100, ack in cycle 1, `rdata`=0xDEADBEEF → no stall; `mem_wdata`=0xDEADBEEF, `mem_wreg`=1; `dbus_sel`=1111.
- **LB vs LBU**, addr 0x103, ack after 3 cycles, `rdata`=0x000000F0 → `stallreq` high for 2 cycles with `mem_wreg`=0; on completion LB gives 0xFFFFFFF0 and LBU gives 0x000000F0; `sel`=0001.
- **SH**, addr 0x202, `reg2`=0x1234ABCD → `dbus_we`=1, `sel`=0011, `wdata`=0xABCDABCD, `addr`=0x200.
- **LW at 0x102** → `align_err`=1 for 1 cycle, `dbus_req`=0, `mem_wreg`=0, no stall.
- **Timeout**: `TIMEOUT`=4, no ack → `dbus_req` high 4 cycles, `bus_err`=1 in the 4th cycle with `stallreq`=0, then IDLE.
- **Reset mid-transaction**: `rst` asserted in WAIT cycle 2 → `dbus_req`, `stallreq` and all outputs drop to 0 asynchronously; after release, a fresh op completes normally.
